// File: rtl/video_stream_pkg.sv
// Shared definitions for the video streaming stages: RGB565 field positions,
// BT.601-style luma weights (sum to 256) and the framing FSM encoding.
package video_stream_pkg;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam logic [7:0] LUMA_R = 8'd77;
    localparam logic [7:0] LUMA_G = 8'd150;
    localparam logic [7:0] LUMA_B = 8'd29;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_DISCARD = 2'd2
    } frame_state_e;

endpackage

// File: rtl/rgb565_luma.sv
// Two-stage RGB565 -> grey datapath with bypass. Stage 1 expands the colour
// fields to 8 bits and applies the luma weights; stage 2 sums, takes the top
// byte and repacks it as RGB565. SOP/EOP travel alongside the pixel. The whole
// pipe advances only when en is high.
module rgb565_luma
    import video_stream_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        vld_in,
    input  logic [15:0] pix_in,
    input  logic        gray_in,
    input  logic        sop_in,
    input  logic        eop_in,
    output logic        vld_out,
    output logic [15:0] pix_out,
    output logic        sop_out,
    output logic        eop_out
);

    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] c);
        return {c, c[5:4]};
    endfunction

    function automatic logic [15:0] pack_gray(input logic [7:0] y);
        return {y[7:3], y[7:2], y[7:3]};
    endfunction

    logic        vld_p1, gray_p1, sop_p1, eop_p1;
    logic [15:0] pix_p1, r_prod_p1, g_prod_p1, b_prod_p1;
    logic        vld_p2, sop_p2, eop_p2;
    logic [15:0] pix_p2;
    logic [7:0]  y_p1;

    // Stage 1: expand colour fields and weight them; keep the raw pixel for bypass
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1    <= 1'b0;
            gray_p1   <= 1'b0;
            sop_p1    <= 1'b0;
            eop_p1    <= 1'b0;
            pix_p1    <= '0;
            r_prod_p1 <= '0;
            g_prod_p1 <= '0;
            b_prod_p1 <= '0;
        end else if (en) begin
            vld_p1    <= vld_in;
            gray_p1   <= gray_in;
            sop_p1    <= sop_in;
            eop_p1    <= eop_in;
            pix_p1    <= pix_in;
            r_prod_p1 <= 16'(expand5(pix_in[R_MSB:R_LSB])) * 16'(LUMA_R);
            g_prod_p1 <= 16'(expand6(pix_in[G_MSB:G_LSB])) * 16'(LUMA_G);
            b_prod_p1 <= 16'(expand5(pix_in[B_MSB:B_LSB])) * 16'(LUMA_B);
        end
    end

    // Weights sum to 256 and each field is at most 255, so the 16-bit sum never wraps
    assign y_p1 = 8'((r_prod_p1 + g_prod_p1 + b_prod_p1) >> 8);

    // Stage 2: sum, take the integer luma and select grey or bypass
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2 <= 1'b0;
            sop_p2 <= 1'b0;
            eop_p2 <= 1'b0;
            pix_p2 <= '0;
        end else if (en) begin
            vld_p2 <= vld_p1;
            sop_p2 <= sop_p1;
            eop_p2 <= eop_p1;
            pix_p2 <= gray_p1 ? pack_gray(y_p1) : pix_p1;
        end
    end

    assign vld_out = vld_p2;
    assign pix_out = pix_p2;
    assign sop_out = sop_p2;
    assign eop_out = eop_p2;

endmodule

// File: rtl/video_gray_filter_stage.sv
// Avalon-ST grey/bypass filter stage. Checks frame geometry on accepted beats,
// drops beats outside a frame, forces EOP on over-long frames and counts
// malformed frames. Pixel processing lives in rgb565_luma.
module video_gray_filter_stage
    import video_stream_pkg::*;
#(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [15:0] data_in,
    input  logic        sop_in,
    input  logic        eop_in,
    output logic        ready_out,
    output logic        valid_out,
    output logic [15:0] data_out,
    output logic        sop_out,
    output logic        eop_out,
    input  logic        ready_in,
    input  logic        gray_en,
    input  logic        err_clear,
    output logic        frame_error,
    output logic [7:0]  err_count
);

    localparam logic [CNT_W-1:0] FRAME_PIX  = CNT_W'(FRAME_WIDTH * FRAME_HEIGHT);
    localparam bit               SINGLE_PIX = (FRAME_WIDTH * FRAME_HEIGHT == 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    frame_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             gray_q, gray_d;
    logic             advance, accept, cnt_last;
    logic             fwd, fwd_sop, fwd_eop, fwd_gray, bad_beat;

    // Stage 2 empty or draining frees the whole pipe; held low while in reset
    assign advance   = ~valid_out | ready_in;
    assign ready_out = reset & advance;
    assign accept    = valid_in & ready_out;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign cnt_last  = (cnt_inc == FRAME_PIX);

    // Framing state, pixel counter and mode latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gray_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gray_q  <= gray_d;
        end
    end

    // Next state: any SOP opens a frame; ACTIVE closes on EOP or when the count fills
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (sop_in) begin
                if (eop_in)          state_d = ST_IDLE;
                else if (SINGLE_PIX) state_d = ST_DISCARD;
                else                 state_d = ST_ACTIVE;
            end else begin
                unique case (state_q)
                    ST_ACTIVE: begin
                        if (eop_in)        state_d = ST_IDLE;
                        else if (cnt_last) state_d = ST_DISCARD;
                    end
                    ST_DISCARD: if (eop_in) state_d = ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

    // Beat decisions: forward/drop, EOP forcing, error flag, counter and mode updates
    always_comb begin
        fwd      = 1'b0;
        fwd_sop  = 1'b0;
        fwd_eop  = 1'b0;
        fwd_gray = gray_q;
        bad_beat = 1'b0;
        cnt_d    = cnt_q;
        gray_d   = gray_q;
        if (accept) begin
            if (sop_in) begin
                fwd      = 1'b1;
                fwd_sop  = 1'b1;
                fwd_gray = gray_en;
                gray_d   = gray_en;
                cnt_d    = CNT_W'(1);
                // A SOP inside an open frame abandons that frame without closing it
                bad_beat = (state_q == ST_ACTIVE);
                if (eop_in) begin
                    fwd_eop = 1'b1;
                    if (!SINGLE_PIX) bad_beat = 1'b1;
                end else if (SINGLE_PIX) begin
                    fwd_eop  = 1'b1;
                    bad_beat = 1'b1;
                end
            end else if (state_q == ST_ACTIVE) begin
                fwd   = 1'b1;
                cnt_d = cnt_inc;
                if (eop_in) begin
                    fwd_eop  = 1'b1;
                    bad_beat = ~cnt_last;
                end else if (cnt_last) begin
                    fwd_eop  = 1'b1;
                    bad_beat = 1'b1;
                end
            end
        end
    end

    // Sticky error flag and saturating malformed-frame counter; clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_error <= 1'b0;
            err_count   <= '0;
        end else if (err_clear) begin
            frame_error <= 1'b0;
            err_count   <= '0;
        end else if (bad_beat) begin
            frame_error <= 1'b1;
            err_count   <= sat_inc(err_count);
        end
    end

    rgb565_luma u_luma (
        .clk     (clk),
        .reset   (reset),
        .en      (advance),
        .vld_in  (fwd),
        .pix_in  (data_in),
        .gray_in (fwd_gray),
        .sop_in  (fwd_sop),
        .eop_in  (fwd_eop),
        .vld_out (valid_out),
        .pix_out (data_out),
        .sop_out (sop_out),
        .eop_out (eop_out)
    );

endmodule
